// File: rtl/seg_scan_ctrl_if.sv
// Display-side bus for the six-digit seven-segment scan controller.
// The master supplies the enable and the display word. The slave (the
// scanner) drives the digit select, the segment pattern and the load pulse.
interface seg_scan_ctrl_if;
  logic        en;
  logic [23:0] data;
  logic        data_vld;
  logic [5:0]  dp_en;
  logic        blank_lz;
  logic [2:0]  bit_disp;
  logic [7:0]  seg_led;
  logic        load_ack;

  modport master (
    output en, data, data_vld, dp_en, blank_lz,
    input  bit_disp, seg_led, load_ack
  );

  modport slave (
    input  en, data, data_vld, dp_en, blank_lz,
    output bit_disp, seg_led, load_ack
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed seven-segment scanner.
// Each digit owns a slot of SCAN_DIV cycles. The first DEAD_CYC cycles of a
// slot are blanked to avoid ghosting while the digit drivers switch.
// A new display word waits in a pending register and is committed to the
// shadow register only at a frame boundary, or while the scanner is idle,
// so a frame never shows a mix of two words.
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DEAD, SHOW} state_t;

  localparam logic [15:0] SLOT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYC - 1);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_digit, w_digit_nxt;
  logic [15:0] r_slot,  w_slot_nxt;

  logic [23:0] r_sh_data, r_pd_data, w_sh_data_nxt;
  logic [5:0]  r_sh_dp,   r_pd_dp,   w_sh_dp_nxt;
  logic        r_sh_lz,   r_pd_lz,   w_sh_lz_nxt;
  logic        r_pd_flag;

  logic [2:0]  r_bit_disp, w_bit_nxt;
  logic [7:0]  r_seg_led,  w_seg_nxt;
  logic        r_load_ack;

  logic        w_boundary, w_bnd_apply, w_idle_apply, w_apply, w_blank;

  // Active-low segment pattern (g..a) for one hex nibble.
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A digit is a suppressed leading zero when it and every more-significant
  // digit are zero. Digit 0 always shows so that a value of 0 stays visible.
  function automatic logic lz_blank(input logic [23:0] d, input logic [2:0] k,
                                    input logic lz);
    logic [23:0] upper;
    upper = d >> {k, 2'b00};
    return lz && (k != 3'd0) && (upper == 24'd0);
  endfunction

  // Word commit points: the last cycle of digit 5 (a strobe in that same
  // cycle wins over the pending word), or any idle cycle with a word pending.
  always_comb begin
    w_boundary    = (r_state == SHOW) && (r_digit == 3'd5) && (r_slot == SLOT_LAST);
    w_bnd_apply   = w_boundary && (r_pd_flag || bus.data_vld);
    w_idle_apply  = (r_state == IDLE) && r_pd_flag;
    w_apply       = w_bnd_apply || w_idle_apply;
    w_sh_data_nxt = r_sh_data;
    w_sh_dp_nxt   = r_sh_dp;
    w_sh_lz_nxt   = r_sh_lz;
    if (w_bnd_apply && bus.data_vld) begin
      w_sh_data_nxt = bus.data;
      w_sh_dp_nxt   = bus.dp_en;
      w_sh_lz_nxt   = bus.blank_lz;
    end else if (w_apply) begin
      w_sh_data_nxt = r_pd_data;
      w_sh_dp_nxt   = r_pd_dp;
      w_sh_lz_nxt   = r_pd_lz;
    end
  end

  // Next-state logic for the scan FSM and its digit and slot counters.
  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    w_slot_nxt  = r_slot;
    case (r_state)
      IDLE: begin
        w_state_nxt = DEAD;
        w_digit_nxt = 3'd0;
        w_slot_nxt  = 16'd0;
      end
      DEAD: begin
        w_slot_nxt = r_slot + 16'd1;
        if (r_slot == DEAD_LAST) w_state_nxt = SHOW;
      end
      SHOW: begin
        if (r_slot == SLOT_LAST) begin
          w_slot_nxt  = 16'd0;
          w_digit_nxt = (r_digit == 3'd5) ? 3'd0 : r_digit + 3'd1;
          w_state_nxt = DEAD;
        end else begin
          w_slot_nxt = r_slot + 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!bus.en) begin
      w_state_nxt = IDLE;
      w_digit_nxt = 3'd0;
      w_slot_nxt  = 16'd0;
    end
  end

  // Outputs are computed from the next state, digit and shadow, then
  // registered, so they change on the same edge as the FSM.
  always_comb begin
    w_bit_nxt = 3'b111;
    w_seg_nxt = 8'hFF;
    w_blank   = lz_blank(w_sh_data_nxt, w_digit_nxt, w_sh_lz_nxt);
    if (w_state_nxt == SHOW) begin
      w_bit_nxt = w_digit_nxt;
      w_seg_nxt = {~w_sh_dp_nxt[w_digit_nxt],
                   w_blank ? 7'h7F : hex2seg(w_sh_data_nxt[{w_digit_nxt, 2'b00} +: 4])};
    end
  end

  // FSM, counters and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_digit    <= 3'd0;
      r_slot     <= 16'd0;
      r_bit_disp <= 3'b111;
      r_seg_led  <= 8'hFF;
      r_load_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_digit    <= w_digit_nxt;
      r_slot     <= w_slot_nxt;
      r_bit_disp <= w_bit_nxt;
      r_seg_led  <= w_seg_nxt;
      r_load_ack <= w_apply;
    end
  end

  // Pending and shadow word registers; the latest strobe overwrites pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_data <= 24'd0;
      r_sh_dp   <= 6'd0;
      r_sh_lz   <= 1'b0;
      r_pd_data <= 24'd0;
      r_pd_dp   <= 6'd0;
      r_pd_lz   <= 1'b0;
      r_pd_flag <= 1'b0;
    end else begin
      r_sh_data <= w_sh_data_nxt;
      r_sh_dp   <= w_sh_dp_nxt;
      r_sh_lz   <= w_sh_lz_nxt;
      if (w_bnd_apply) begin
        r_pd_flag <= 1'b0;
      end else if (bus.data_vld) begin
        r_pd_data <= bus.data;
        r_pd_dp   <= bus.dp_en;
        r_pd_lz   <= bus.blank_lz;
        r_pd_flag <= 1'b1;
      end else if (w_idle_apply) begin
        r_pd_flag <= 1'b0;
      end
    end
  end

  assign bus.bit_disp = r_bit_disp;
  assign bus.seg_led  = r_seg_led;
  assign bus.load_ack = r_load_ack;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with a small scan geometry (8-cycle slots, 2 dead
// cycles). The reference model tracks the position in the 48-cycle frame as
// a plain counter and derives digit and slot from it arithmetically.
module tb_seg_scan_ctrl;
  localparam int SCAN_DIV = 8;
  localparam int DEAD_CYC = 2;
  localparam int FRAME    = 6 * SCAN_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEAD_CYC(DEAD_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_ack    = 0;

  // Reference model state
  bit          m_active;
  int          m_t;
  logic [23:0] m_sh_data, m_pd_data;
  logic [5:0]  m_sh_dp,   m_pd_dp;
  logic        m_sh_lz,   m_pd_lz, m_pd_flag;
  logic        m_ack;

  logic [7:0]  obs [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[h];
  endfunction

  function automatic logic [2:0] exp_bit();
    if (!m_active || (m_t % SCAN_DIV) < DEAD_CYC) return 3'b111;
    return 3'(m_t / SCAN_DIV);
  endfunction

  function automatic logic [7:0] exp_seg();
    int  d;
    bit  blank;
    if (!m_active || (m_t % SCAN_DIV) < DEAD_CYC) return 8'hFF;
    d = m_t / SCAN_DIV;
    blank = 0;
    if (m_sh_lz && d > 0) begin
      blank = 1;
      for (int k = d; k < 6; k++)
        if (m_sh_data[4*k +: 4] != 4'd0) blank = 0;
    end
    return {~m_sh_dp[d], blank ? 7'h7F : hex_seg(m_sh_data[4*d +: 4])};
  endfunction

  task automatic model_reset();
    m_active  = 0;  m_t = 0;
    m_sh_data = '0; m_sh_dp = '0; m_sh_lz = 0;
    m_pd_data = '0; m_pd_dp = '0; m_pd_lz = 0; m_pd_flag = 0;
    m_ack     = 0;
  endtask

  // One rising edge of the reference model, using the inputs held at that edge.
  task automatic model_edge();
    bit boundary, idle_take;
    boundary  = m_active && (m_t == FRAME - 1);
    idle_take = !m_active && m_pd_flag;
    m_ack = 0;
    if (boundary && (m_pd_flag || bus.data_vld)) begin
      m_ack = 1;
      if (bus.data_vld) begin
        m_sh_data = bus.data; m_sh_dp = bus.dp_en; m_sh_lz = bus.blank_lz;
      end else begin
        m_sh_data = m_pd_data; m_sh_dp = m_pd_dp; m_sh_lz = m_pd_lz;
      end
      m_pd_flag = 0;
    end else begin
      if (idle_take) begin
        m_ack = 1;
        m_sh_data = m_pd_data; m_sh_dp = m_pd_dp; m_sh_lz = m_pd_lz;
        m_pd_flag = 0;
      end
      if (bus.data_vld) begin
        m_pd_data = bus.data; m_pd_dp = bus.dp_en; m_pd_lz = bus.blank_lz;
        m_pd_flag = 1;
      end
    end
    if (!bus.en)        begin m_active = 0; m_t = 0; end
    else if (!m_active) begin m_active = 1; m_t = 0; end
    else                m_t = (m_t + 1) % FRAME;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check("bit_disp", 32'(bus.bit_disp), 32'(exp_bit()));
    check("seg_led",  32'(bus.seg_led),  32'(exp_seg()));
    check("load_ack", 32'(bus.load_ack), 32'(m_ack));
    if (bus.load_ack) n_ack++;
    bus.data_vld = 1'b0;
  endtask

  task automatic strobe(input logic [23:0] d, input logic [5:0] dp, input logic lz);
    bus.data = d; bus.dp_en = dp; bus.blank_lz = lz; bus.data_vld = 1'b1;
  endtask

  task automatic capture_frame();
    for (int i = 0; i < 6; i++) obs[i] = 8'h00;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      if (bus.bit_disp < 3'd6) obs[bus.bit_disp] = bus.seg_led;
    end
  endtask

  // Advance until the model reaches frame position pos; false if never reached.
  task automatic seek(input int pos, output bit found);
    found = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (m_active && m_t == pos) begin found = 1; break; end
      cycle();
    end
  endtask

  initial begin
    bit found;
    bus.en = 1'b0; bus.data = '0; bus.data_vld = 1'b0; bus.dp_en = '0; bus.blank_lz = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_bit_disp", 32'(bus.bit_disp), 32'h7);
    check("rst_seg_led",  32'(bus.seg_led),  32'hFF);
    check("rst_load_ack", 32'(bus.load_ack), 32'h0);
    rst_n = 1'b1;

    // Word loaded while idle, then scanning starts.
    strobe(24'h123456, 6'b000000, 1'b0);
    cycle();
    cycle();
    cycle();
    check("idle_ack_once", 32'(n_ack), 32'd1);
    bus.en = 1'b1;
    cycle();
    check("first_dead_bit", 32'(bus.bit_disp), 32'h7);
    capture_frame();
    check("hex_digit0", 32'(obs[0]), 32'h82);
    check("hex_digit5", 32'(obs[5]), 32'hF9);

    // Leading-zero suppression.
    strobe(24'h000070, 6'b000000, 1'b1);
    repeat (FRAME + 1) cycle();
    capture_frame();
    for (int k = 2; k < 6; k++) check("lz_blank_hi", 32'(obs[k]), 32'hFF);
    check("lz_digit1", 32'(obs[1]), 32'hF8);
    check("lz_digit0", 32'(obs[0]), 32'hC0);

    // Decimal point on digit 2 only.
    strobe(24'h000000, 6'b000100, 1'b0);
    repeat (FRAME + 1) cycle();
    capture_frame();
    for (int k = 0; k < 6; k++)
      check("dp_digit", 32'(obs[k]), (k == 2) ? 32'h40 : 32'hC0);

    // Two strobes in one frame: latest wins, single acknowledge.
    seek(20, found);
    check("seek_mid", 32'(found), 32'd1);
    n_ack = 0;
    strobe(24'hAAAAAA, 6'b111111, 1'b0);
    cycle();
    cycle();
    strobe(24'hBCDEF0, 6'b000001, 1'b0);
    repeat (2 * FRAME) cycle();
    check("ab_ack_once", 32'(n_ack), 32'd1);

    // Strobe exactly on the frame boundary.
    seek(FRAME - 1, found);
    check("seek_bnd", 32'(found), 32'd1);
    strobe(24'h987654, 6'b000010, 1'b0);
    cycle();
    check("bnd_ack", 32'(bus.load_ack), 32'd1);
    repeat (FRAME) cycle();

    // Enable dropped while digit 3 is shown.
    seek(3 * SCAN_DIV + DEAD_CYC + 1, found);
    check("seek_d3", 32'(found), 32'd1);
    bus.en = 1'b0;
    cycle();
    check("endrop_bit", 32'(bus.bit_disp), 32'h7);
    check("endrop_seg", 32'(bus.seg_led),  32'hFF);
    cycle();
    bus.en = 1'b1;
    repeat (FRAME) cycle();

    // Randomized traffic with occasional enable drops and one async reset.
    for (int i = 0; i < 1500; i++) begin
      bus.en = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 24) == 0)
        strobe(24'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 6))),
               6'($urandom), 1'($urandom));
      if (i == 700) begin
        bus.data_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_bit", 32'(bus.bit_disp), 32'h7);
        check("async_rst_seg", 32'(bus.seg_led),  32'hFF);
        check("async_rst_ack", 32'(bus.load_ack), 32'h0);
        cycle();
        @(negedge clk);
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
